// File: rtl/pia_pkg.sv
// Shared types and helpers for the PIA input-handshake byte transmitter.
package pia_pkg;

    localparam int unsigned PIA_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWaitAck
    } pia_tx_state_e;

    // Idle CA1 level is the opposite of the active level.
    function automatic logic ca1_idle_level(input bit active_high);
        return ~active_high;
    endfunction

endpackage

// File: rtl/pia_tx_fifo.sv
// Synchronous byte FIFO with count-based full/empty flags.
module pia_tx_fifo
    import pia_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [PIA_DATA_W-1:0] wdata,
    output logic [PIA_DATA_W-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [PIA_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [AW:0]           count_q;
    logic                  do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            // Simultaneous push and pop leave the count unchanged.
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pia_handshake_tx.sv
// Byte transmitter into a 6820-style PIA port A: strobes CA1, waits for a CA2 falling edge.
// Optional ack watchdog enabled by defining PIA_TX_TIMEOUT_EN.
module pia_handshake_tx
    import pia_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned SETUP_CYCLES    = 2,
    parameter int unsigned STROBE_CYCLES   = 4,
    parameter bit          CA1_ACTIVE_HIGH = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PIA_DATA_W-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [PIA_DATA_W-1:0] pa_o,
    output logic                  ca1_o,
    input  logic                  ca2_i,
    output logic                  busy,
    output logic                  timeout_o
);

    // Counter is sized for the watchdog limit too, so both builds share one parameter set.
    localparam int unsigned MAX_SS  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_SS > TIMEOUT_CYCLES) ? MAX_SS : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic        CA1_IDLE = ca1_idle_level(CA1_ACTIVE_HIGH);

    pia_tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PIA_DATA_W-1:0] pa_q, fifo_rdata;
    logic                  fifo_full, fifo_empty, pop;
    logic                  ca2_meta_q, ca2_sync_q, ca2_prev_q, ca2_fall_q;

    assign s_ready = ~fifo_full;
    assign pa_o    = pa_q;

    pia_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (s_valid & ~fifo_full),
        .pop     (pop),
        .wdata   (s_data),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ca2 is asynchronous; the registered fall pulse is the only thing the FSM sees.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ca2_meta_q <= 1'b1;
            ca2_sync_q <= 1'b1;
            ca2_prev_q <= 1'b1;
            ca2_fall_q <= 1'b0;
        end else begin
            ca2_meta_q <= ca2_i;
            ca2_sync_q <= ca2_meta_q;
            ca2_prev_q <= ca2_sync_q;
            ca2_fall_q <= ca2_prev_q & ~ca2_sync_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PIA_TX_TIMEOUT_EN
    logic tmo_d, timeout_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
`ifdef PIA_TX_TIMEOUT_EN
        tmo_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StSetup;
                    cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StStrobe;
                    cnt_d   = CNT_W'(STROBE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d = StWaitAck;
`ifdef PIA_TX_TIMEOUT_EN
                    cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
`else
                    cnt_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWaitAck: begin
                if (ca2_fall_q) begin
                    state_d = StIdle;
`ifdef PIA_TX_TIMEOUT_EN
                end else if (cnt_q == '0) begin
                    state_d = StIdle;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ca1_o = (state_q == StStrobe) ? ~CA1_IDLE : CA1_IDLE;
        busy  = (state_q != StIdle) | ~fifo_empty;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            pa_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (pop) begin
                pa_q <= fifo_rdata;
            end
        end
    end

`ifdef PIA_TX_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= tmo_d;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pia_handshake_tx.sv
// Directed self-checking bench for pia_handshake_tx (falling- and rising-edge CA1 instances).
module tb_pia_handshake_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] s_data, s_data_h;
    logic       s_valid, s_valid_h;
    logic       ca2, ca2_h;
    logic       s_ready, s_ready_h;
    logic [7:0] pa_o, pa_h;
    logic       ca1_o, ca1_h;
    logic       busy, busy_h;
    logic       timeout_o, timeout_h;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pia_handshake_tx #(
        .DEPTH (4), .SETUP_CYCLES (2), .STROBE_CYCLES (4),
        .CA1_ACTIVE_HIGH (1'b0), .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk (clk), .reset_n (reset_n), .s_data (s_data), .s_valid (s_valid),
        .s_ready (s_ready), .pa_o (pa_o), .ca1_o (ca1_o), .ca2_i (ca2),
        .busy (busy), .timeout_o (timeout_o)
    );

    pia_handshake_tx #(
        .DEPTH (4), .SETUP_CYCLES (2), .STROBE_CYCLES (4),
        .CA1_ACTIVE_HIGH (1'b1), .TIMEOUT_CYCLES (16)
    ) u_dut_hi (
        .clk (clk), .reset_n (reset_n), .s_data (s_data_h), .s_valid (s_valid_h),
        .s_ready (s_ready_h), .pa_o (pa_h), .ca1_o (ca1_h), .ca2_i (ca2_h),
        .busy (busy_h), .timeout_o (timeout_h)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; s_valid = 1'b0; s_data = '0; ca2 = 1'b1;
        s_valid_h = 1'b0; s_data_h = '0; ca2_h = 1'b1;
        #2;
        checks++; if (pa_o !== 8'h00) begin errors++; $display("FAIL rst_pa got %h want 00", pa_o); end
        checks++; if (ca1_o !== 1'b1) begin errors++; $display("FAIL rst_ca1 got %b want 1", ca1_o); end
        checks++; if (ca1_h !== 1'b0) begin errors++; $display("FAIL rst_ca1_hi got %b want 0", ca1_h); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL rst_tmo got %b want 0", timeout_o); end
        tick; tick;
        reset_n = 1'b1;
        tick; tick;
    endtask

    task automatic test_single_byte;
        int first_low = -100;
        int lows = 0;
        s_data = 8'hA5; s_valid = 1'b1;
        tick;
        s_valid = 1'b0;
        checks++; if (pa_o !== 8'h00) begin errors++; $display("FAIL single_pa_early got %h want 00", pa_o); end
        tick;
        checks++; if (pa_o !== 8'hA5) begin errors++; $display("FAIL single_pa got %h want a5", pa_o); end
        for (int i = 0; i < 14; i++) begin
            if (ca1_o === 1'b0) begin
                lows++;
                if (first_low < 0) first_low = i;
            end
            if (i == first_low + 8) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_ack got %b want 1", busy); end
            end
            if (i == first_low + 9) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", busy); end
            end
            if (i == first_low + 5) ca2 = 1'b0;
            tick;
        end
        checks++; if (lows != 4) begin errors++; $display("FAIL single_low_len got %0d want 4", lows); end
        checks++; if (first_low != 2) begin errors++; $display("FAIL single_setup got %0d want 2", first_low); end
        checks++; if (pa_o !== 8'hA5) begin errors++; $display("FAIL single_pa_hold got %h want a5", pa_o); end
        ca2 = 1'b1;
        tick; tick; tick; tick;
    endtask

    task automatic test_burst;
        int sent = 0;
        int strobes = 0;
        int ack_cd = 0;
        int rel_cd = 0;
        logic ca1_prev = 1'b1;
        logic rdy;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (ca1_prev === 1'b1 && ca1_o === 1'b0) begin
                checks++;
                if (pa_o !== 8'(strobes + 1)) begin
                    errors++; $display("FAIL burst_order got %h want %h", pa_o, 8'(strobes + 1));
                end
                strobes++;
                ack_cd = 8;
            end
            ca1_prev = ca1_o;
            if (cyc == 12) begin
                checks++; if (sent != 5) begin errors++; $display("FAIL burst_accepted got %0d want 5", sent); end
                checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL burst_full_ready got %b want 0", s_ready); end
            end
            if (rel_cd > 0) begin
                rel_cd--;
                if (rel_cd == 0) ca2 = 1'b1;
            end
            if (cyc >= 12 && ack_cd > 0) begin
                ack_cd--;
                if (ack_cd == 0) begin ca2 = 1'b0; rel_cd = 3; end
            end
            if (strobes == 6 && sent == 6 && busy === 1'b0) break;
            s_valid = (sent < 6);
            s_data  = 8'(sent + 1);
            rdy     = s_ready;
            tick;
            if (s_valid && rdy) sent++;
        end
        s_valid = 1'b0;
        ca2 = 1'b1;
        checks++; if (strobes != 6) begin errors++; $display("FAIL burst_strobes got %0d want 6", strobes); end
        checks++; if (sent != 6) begin errors++; $display("FAIL burst_sent got %0d want 6", sent); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_done_busy got %b want 0", busy); end
        tick; tick; tick; tick;
    endtask

    task automatic test_stale_level;
        bit ok;
        s_data = 8'h5A; s_valid = 1'b1; ca2 = 1'b0;
        tick;
        s_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (ca1_o === 1'b0) begin ok = 1; break; end
            tick;
        end
        checks++; if (!ok) begin errors++; $display("FAIL stale_strobe got none want ca1 low"); end
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (ca1_o === 1'b1) begin ok = 1; break; end
            tick;
        end
        checks++; if (!ok) begin errors++; $display("FAIL stale_strobe_end got low want ca1 high"); end
        for (int i = 0; i < 30; i++) tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stale_hold got %b want 1", busy); end
        ca2 = 1'b1;
        tick; tick; tick;
        ca2 = 1'b0;
        tick; tick; tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stale_ack_early got %b want 1", busy); end
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stale_ack got %b want 0", busy); end
        checks++; if (pa_o !== 8'h5A) begin errors++; $display("FAIL stale_pa got %h want 5a", pa_o); end
        ca2 = 1'b1;
        tick; tick; tick; tick;
    endtask

    task automatic test_timeout;
        bit ok;
        int pulses = 0;
        s_data = 8'h11; s_valid = 1'b1;
        tick;
`ifdef PIA_TX_TIMEOUT_EN
        s_data = 8'h22;
        tick;
`endif
        s_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (ca1_o === 1'b0) begin ok = 1; break; end
            tick;
        end
        checks++; if (!ok) begin errors++; $display("FAIL tmo_strobe got none want ca1 low"); end
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (ca1_o === 1'b1) begin ok = 1; break; end
            tick;
        end
        checks++; if (!ok) begin errors++; $display("FAIL tmo_strobe_end got low want ca1 high"); end
`ifdef PIA_TX_TIMEOUT_EN
        for (int k = 0; k < 18; k++) begin
            checks++;
            if (timeout_o !== (k == 16)) begin
                errors++; $display("FAIL tmo_pulse k=%0d got %b want %b", k, timeout_o, (k == 16));
            end
            if (timeout_o === 1'b1) pulses++;
            tick;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL tmo_count got %0d want 1", pulses); end
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (ca1_o === 1'b0) begin ok = 1; break; end
            tick;
        end
        checks++; if (!ok || pa_o !== 8'h22) begin
            errors++; $display("FAIL tmo_next_byte got %h want 22", pa_o);
        end
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy === 1'b0) begin ok = 1; break; end
            tick;
        end
        checks++; if (!ok) begin errors++; $display("FAIL tmo_drain got busy want idle"); end
`else
        for (int i = 0; i < 1000; i++) begin
            if (timeout_o !== 1'b0) pulses++;
            tick;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL tmo_tied got %0d want 0", pulses); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_wait_forever got %b want 1", busy); end
        ca2 = 1'b0;
        tick; tick; tick; tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_late_ack got %b want 0", busy); end
        ca2 = 1'b1;
`endif
        tick; tick; tick; tick;
    endtask

    task automatic test_reset_mid;
        bit ok = 0;
        for (int b = 0; b < 3; b++) begin
            s_data = 8'h71 + 8'(b); s_valid = 1'b1;
            tick;
        end
        s_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ca1_o === 1'b0) begin ok = 1; break; end
            tick;
        end
        checks++; if (!ok) begin errors++; $display("FAIL rmid_strobe got none want ca1 low"); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (ca1_o !== 1'b1) begin errors++; $display("FAIL rmid_ca1 got %b want 1", ca1_o); end
        checks++; if (pa_o !== 8'h00) begin errors++; $display("FAIL rmid_pa got %h want 00", pa_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        tick;
        reset_n = 1'b1;
        tick; tick; tick;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_empty got %b want 0", busy); end
        checks++; if (ca1_o !== 1'b1) begin errors++; $display("FAIL rmid_no_strobe got %b want 1", ca1_o); end
    endtask

    task automatic test_active_high;
        int first_high = -100;
        int highs = 0;
        checks++; if (ca1_h !== 1'b0) begin errors++; $display("FAIL hi_idle got %b want 0", ca1_h); end
        s_data_h = 8'h3C; s_valid_h = 1'b1;
        tick;
        s_valid_h = 1'b0;
        tick;
        checks++; if (pa_h !== 8'h3C) begin errors++; $display("FAIL hi_pa got %h want 3c", pa_h); end
        for (int i = 0; i < 14; i++) begin
            if (ca1_h === 1'b1) begin
                highs++;
                if (first_high < 0) first_high = i;
            end
            if (i == first_high + 8) begin
                checks++; if (busy_h !== 1'b1) begin errors++; $display("FAIL hi_busy_ack got %b want 1", busy_h); end
            end
            if (i == first_high + 9) begin
                checks++; if (busy_h !== 1'b0) begin errors++; $display("FAIL hi_idle_after got %b want 0", busy_h); end
            end
            if (i == first_high + 5) ca2_h = 1'b0;
            tick;
        end
        checks++; if (highs != 4) begin errors++; $display("FAIL hi_len got %0d want 4", highs); end
        checks++; if (first_high != 2) begin errors++; $display("FAIL hi_setup got %0d want 2", first_high); end
        checks++; if (ca1_h !== 1'b0) begin errors++; $display("FAIL hi_return got %b want 0", ca1_h); end
        ca2_h = 1'b1;
        tick; tick;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_stale_level();
        test_timeout();
        test_reset_mid();
        test_active_high();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/pia_handshake_tx.md
# pia_handshake_tx

Peripheral-side byte transmitter driving a 6820-style PIA port in input-handshake mode. Accepts bytes on a valid/ready stream, buffers them, presents each on the PIA port-A data lines, and pulses CA1 as the data strobe. It then waits for the PIA's CA2 read-acknowledge before sending the next byte. It sits between a host-side byte source (keyboard scanner, serial bridge) and the PIA's PAI/CA1/CA2 pins.

## Interface
- DEPTH, 4: FIFO entries, power of two, ≥2.
- SETUP_CYCLES, 2: cycles pa_o is stable before the CA1 active edge, ≥1.
- STROBE_CYCLES, 4: cycles CA1 is held at its active level, ≥1.
- CA1_ACTIVE_HIGH, 0: 0 = falling edge is active (CA1 idles high); 1 = rising edge is active (CA1 idles low).
- TIMEOUT_CYCLES, 1024: WAIT_ACK limit; used only with the macro.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- s_data  in  8  byte to send.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO not full.
- pa_o  out  8  to PIA PAI.
- ca1_o  out  1  to PIA CA1 (strobe).
- ca2_i  in  1  from PIA CA2 (ack; asynchronous to clk).
- busy  out  1  state ≠ IDLE or FIFO not empty.
- timeout_o  out  1  one-cycle pulse on ack timeout.

## Operation
- FSM states: IDLE, SETUP, STROBE, WAIT_ACK.
- IDLE:
  - ca1_o is at its inactive level.
  - If the FIFO is not empty: pop, load pa_o, go to SETUP.
- SETUP:
  - Counts SETUP_CYCLES.
  - Then goes to STROBE and drives ca1_o to its active level.
- STROBE:
  - Counts STROBE_CYCLES.
  - Then returns ca1_o to inactive and goes to WAIT_ACK.
- WAIT_ACK:
  - ca2_i passes through a 2-flop synchronizer plus an edge register.
  - A falling edge of the synchronized ca2 is the ack; on it, go to IDLE.
  - Only an edge counts, never a level. A stale low level left from the previous byte must not complete a transfer.
- pa_o holds the last byte after completion; it is never cleared except by reset.
- Stream handshake:
  - A push occurs when s_valid && s_ready at the clock edge.
  - s_ready = !full.
  - Push and pop in the same cycle are both honoured and the count is unchanged.
  - When the FIFO is full, s_ready is low. A pop makes s_ready high on the next cycle.
- Counters are $clog2(max)+1 bits wide and saturate-free. Each counter reloads on state entry.
- Reset, including mid-transfer:
  - pa_o=0, ca1_o=inactive level, s_ready=1, busy=0, timeout_o=0.
  - FIFO emptied, state IDLE, synchronizer flops=1.
  - Takes effect asynchronously: ca1_o drops to inactive without waiting for clk.

## Timing
- Push in cycle 0 into an empty FIFO, FSM in IDLE:
  - Pop in cycle 1.
  - pa_o valid from cycle 2.
  - ca1_o active from cycle 2+SETUP_CYCLES for STROBE_CYCLES cycles.
- ca2_i falling at a pin, setup met before edge N: edge detect in cycle N+2, IDLE at N+3.
- Back-to-back bytes: the next pop occurs in the first IDLE cycle. Minimum gap between consecutive CA1 active edges is 1+SETUP_CYCLES+STROBE_CYCLES+3+ack latency.
- A ca2 falling edge outside WAIT_ACK is ignored, but the edge register still tracks it.

## Configuration
- PIA_TX_TIMEOUT_EN defined:
  - A watchdog counts cycles in WAIT_ACK.
  - At TIMEOUT_CYCLES without ack: pulse timeout_o for 1 cycle, drop the byte, go to IDLE.
- PIA_TX_TIMEOUT_EN undefined:
  - No watchdog logic; WAIT_ACK waits indefinitely.
  - timeout_o is tied to 0.
  - TIMEOUT_CYCLES is ignored.

## Structure
- Package pia_pkg:
  - pia_tx_state_e enum (IDLE, SETUP, STROBE, WAIT_ACK).
  - PIA_DATA_W=8.
  - Polarity helper function returning the inactive CA1 level from CA1_ACTIVE_HIGH.
- Sub-module pia_tx_fifo:
  - Synchronous FIFO parameterised by DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty; asynchronous reset.
- Top level contains the FSM, counters, ca2 synchronizer and watchdog.

## Test plan
- Single byte 0xA5, CA1_ACTIVE_HIGH=0, model PIA pulls ca2 low 5 cycles after the ca1 fall → pa_o=0xA5 two cycles after push; ca1 low for exactly 4 cycles; IDLE 3 cycles after the ca2 fall; busy=0 after.
- Burst of 6 bytes 0x01..0x06 with DEPTH=4 and ack held off → s_ready drops after 5 accepted (4 in FIFO + 1 in flight); all 6 bytes appear on pa_o in order, one strobe each.
- ca2 held low from before the strobe, no new falling edge → FSM stays in WAIT_ACK; a high-then-low pulse on ca2 completes the transfer.
- With PIA_TX_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack → timeout_o pulses exactly once, 16 cycles after entering WAIT_ACK; the next queued byte is sent. Without the macro → still in WAIT_ACK after 1000 cycles, timeout_o=0.
- reset_n asserted during STROBE with ca1_o low → ca1_o=1 and pa_o=0 immediately, without a clock; FIFO is empty and s_ready=1 after release.
- CA1_ACTIVE_HIGH=1, byte 0x3C → ca1_o idles 0 and goes high for STROBE_CYCLES; ack handled identically.
